// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: two-flop synchronizer, stability debouncer,
// press-event FSM and lowest-index encoder with a valid/ready output.
module keypad_debounce_encoder #(
  parameter int NUM_KEYS        = 12,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                ready,
  output logic [CODE_W-1:0]   code,
  output logic                valid,
  output logic                multi,
  output logic                overrun
);

  typedef enum logic {
    IDLE,
    WAIT_REL
  } state_e;

  localparam logic [7:0] CNT_MAX  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] CNT_LOAD = 8'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] key_sync_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] stable_keys_q, stable_keys_d;
  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                multi_q, multi_d;
  logic                overrun_q, overrun_d;

  logic                chg;
  logic                load;
  logic                evt;
  logic [4:0]          pop;
  logic [CODE_W-1:0]   enc;

  // chg flags the edge on which key_sync takes a new value
  always_comb begin
    chg   = (sync1_q != key_sync_q);
    load  = 1'b0;
    cnt_d = cnt_q;
    if (chg) begin
      cnt_d = '0;
    end else begin
      load  = (cnt_q == CNT_LOAD);
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    stable_keys_d = load ? key_sync_q : stable_keys_q;
  end

  always_comb begin
    pop = '0;
    enc = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      pop = pop + 5'(stable_keys_q[i]);
    end
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (stable_keys_q[i]) begin
        enc = CODE_W'(i);
      end
    end
    multi_d = (pop > 5'd1);
  end

  always_comb begin
    state_d = state_q;
    evt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|stable_keys_q) begin
          evt     = 1'b1;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (~|stable_keys_q) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (evt) begin
      if (!valid_q || ready) begin
        code_d  = enc;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      key_sync_q    <= '0;
      cnt_q         <= '0;
      stable_keys_q <= '0;
      state_q       <= IDLE;
      code_q        <= '0;
      valid_q       <= 1'b0;
      multi_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync1_q       <= key;
      key_sync_q    <= sync1_q;
      cnt_q         <= cnt_d;
      stable_keys_q <= stable_keys_d;
      state_q       <= state_d;
      code_q        <= code_d;
      valid_q       <= valid_d;
      multi_q       <= multi_d;
      overrun_q     <= overrun_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign multi   = multi_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder: vector table for
// encoding plus hand sequences for glitch, overrun and reset.
module tb_keypad_debounce_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] key;
  logic        ready;
  logic [3:0]  code;
  logic        valid;
  logic        multi;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  keypad_debounce_encoder #(
    .NUM_KEYS(12),
    .CODE_W(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .ready(ready),
    .code(code),
    .valid(valid),
    .multi(multi),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] k;
    logic [3:0]  code;
    logic        mlt;
  } vec_t;

  vec_t tbl[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    int pulses;
    int first;
    logic [3:0] got;
    logic m;
    logic any_v;
    logic any_s;

    for (int i = 0; i < 12; i++) begin
      tbl[i].k    = 12'(1 << i);
      tbl[i].code = 4'(i);
      tbl[i].mlt  = 1'b0;
    end
    tbl[12] = '{12'h088, 4'd3, 1'b1};
    tbl[13] = '{12'h01C, 4'd2, 1'b1};
    tbl[14] = '{12'hFFF, 4'd0, 1'b1};

    rst = 1'b1;
    key = '0;
    ready = 1'b0;
    tick();
    tick();
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_multi", 32'(multi), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 15; v++) begin
      key = tbl[v].k;
      ready = 1'b1;
      pulses = 0;
      first = 0;
      got = '0;
      m = 1'b0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (valid) begin
          pulses++;
          got = code;
          if (first == 0) first = t;
        end
        if (t == 10) m = multi;
      end
      key = '0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (valid) pulses++;
      end
      chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd1);
      chk($sformatf("vec%0d_code", v), 32'(got), 32'(tbl[v].code));
      chk($sformatf("vec%0d_multi", v), 32'(m), 32'(tbl[v].mlt));
      if (v == 0) chk("latency", 32'(first), 32'd7);
    end

    // two-cycle glitch on key 5 must not reach stable_keys
    ready = 1'b1;
    key = 12'(1 << 5);
    any_v = 1'b0;
    any_s = 1'b0;
    tick();
    tick();
    key = '0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      any_v = any_v | valid;
      any_s = any_s | (|dut.stable_keys_q);
    end
    chk("glitch_valid", 32'(any_v), 32'd0);
    chk("glitch_stable", 32'(any_s), 32'd0);

    // key 9 joins key 1 mid-hold: still exactly one event
    key = 12'(1 << 1);
    pulses = 0;
    got = '0;
    m = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      if (t == 21) key = key | 12'(1 << 9);
      tick();
      if (valid) begin
        pulses++;
        got = code;
      end
      if (t == 50) m = multi;
    end
    key = '0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (valid) pulses++;
    end
    chk("add_pulses", 32'(pulses), 32'd1);
    chk("add_code", 32'(got), 32'd1);
    chk("add_multi", 32'(m), 32'd1);

    // overrun: second press while the first is still unaccepted
    ready = 1'b0;
    key = 12'(1 << 4);
    for (int t = 1; t <= 10; t++) tick();
    chk("ovr_valid1", 32'(valid), 32'd1);
    chk("ovr_code1", 32'(code), 32'd4);
    chk("ovr_flag1", 32'(overrun), 32'd0);
    key = '0;
    for (int t = 1; t <= 10; t++) tick();
    key = 12'(1 << 6);
    for (int t = 1; t <= 10; t++) tick();
    chk("ovr_valid2", 32'(valid), 32'd1);
    chk("ovr_code2", 32'(code), 32'd4);
    chk("ovr_flag2", 32'(overrun), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ovr_acc_valid", 32'(valid), 32'd0);
    chk("ovr_acc_code", 32'(code), 32'd4);
    chk("ovr_acc_flag", 32'(overrun), 32'd1);
    key = '0;
    for (int t = 1; t <= 10; t++) tick();

    // reset mid-press; held key is reported again afterwards
    key = 12'(1 << 8);
    for (int t = 1; t <= 10; t++) tick();
    chk("rp_valid", 32'(valid), 32'd1);
    chk("rp_code", 32'(code), 32'd8);
    ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b0;
    chk("rp_rst_code", 32'(code), 32'd0);
    chk("rp_rst_valid", 32'(valid), 32'd0);
    chk("rp_rst_multi", 32'(multi), 32'd0);
    chk("rp_rst_overrun", 32'(overrun), 32'd0);
    first = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (valid && first == 0) first = t;
    end
    chk("rp_latency", 32'(first), 32'd7);
    chk("rp_code2", 32'(code), 32'd8);
    chk("rp_overrun2", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_debounce_encoder.md
KEYPAD_DEBOUNCE_ENCODER -- requirements
Module: keypad_debounce_encoder

Interface
REQ-001 SHALL provide parameter NUM_KEYS, default 12, meaning number of raw key inputs; legal range 2..16.
REQ-002 SHALL provide parameter CODE_W, default 4, meaning code width; 2**CODE_W >= NUM_KEYS is required.
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 4, meaning consecutive identical synchronized samples required before a key vector is accepted; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-006 SHALL have port key, input, NUM_KEYS bits, raw asynchronous key levels, 1 = pressed.
REQ-007 SHALL have port ready, input, 1 bit, consumer accepts the current code when high with valid high.
REQ-008 SHALL have port code, output, CODE_W bits, registered index of the reported key.
REQ-009 SHALL have port valid, output, 1 bit, registered; code holds a pending press event.
REQ-010 SHALL have port multi, output, 1 bit, registered; debounced vector has more than one bit set.
REQ-011 SHALL have port overrun, output, 1 bit, sticky; a press event was dropped.

Function
REQ-012 SHALL pass key through a two-flop synchronizer; the second stage is key_sync.
REQ-013 SHALL keep a stability counter: it clears when key_sync differs from its previous-cycle value and increments otherwise, saturating at DEBOUNCE_CYCLES.
REQ-014 SHALL load the debounced vector stable_keys with key_sync on the edge where key_sync has been identical for DEBOUNCE_CYCLES consecutive edges.
REQ-015 SHALL leave stable_keys unchanged if key_sync toggles before DEBOUNCE_CYCLES identical samples (glitch rejected).
REQ-016 SHALL implement a two-state FSM: IDLE and WAIT_RELEASE.
REQ-017 SHALL, in IDLE with stable_keys nonzero, generate one press event and move to WAIT_RELEASE.
REQ-018 SHALL, in WAIT_RELEASE, generate no events and return to IDLE when stable_keys is all zero.
REQ-019 SHALL not generate an event when further keys are added while in WAIT_RELEASE.
REQ-020 SHALL encode a press event as the lowest-index set bit of stable_keys, zero-extended to CODE_W bits.
REQ-021 SHALL, on a press event with valid low or with valid and ready both high, register code and set valid on the same edge.
REQ-022 SHALL, on valid and ready high with no new event, clear valid on that edge; code holds its last value.
REQ-023 SHALL, on a press event with valid high and ready low, keep code and valid unchanged, drop the event, and set overrun.
REQ-024 SHALL clear overrun only on rst.
REQ-025 SHALL update multi one edge after stable_keys changes, based on the population count of stable_keys exceeding 1.
REQ-026 SHALL have latency from raw key applied before edge 0 and held constant to valid high after edge 2+DEBOUNCE_CYCLES (edge 6 at default).
REQ-027 SHALL keep valid high and code stable until accepted, independent of key activity.

Reset
REQ-028 SHALL, on rst high at a clock edge, clear the synchronizer, stability counter, stable_keys, code, valid, multi and overrun to 0, and set the FSM to IDLE.
REQ-029 SHALL give rst priority over every other event, including a press event and a handshake on the same edge.
REQ-030 SHALL, after rst mid-press with key still held, report the held key again as a new event once it has been debounced.

Verification
REQ-031 Key[i] alone, for each i 0..11, held 10 cycles with ready=1 -> one valid pulse with code=i; 4'b1011 for i=11.
REQ-032 Keys 3 and 7 held -> code=4'b0011 and multi=1; keys 2,3,4 -> code=4'b0010; all keys -> code=4'b0000 and multi=1.
REQ-033 Key 5 high for 2 cycles only, DEBOUNCE_CYCLES=4 -> valid stays 0 and stable_keys stays 0.
REQ-034 Key 1 held for 50 cycles, key 9 added at cycle 20, ready=1 -> exactly one event, with code=4'b0001.
REQ-035 ready=0: press and release key 4, then press key 6 -> valid=1, code=4'b0100 retained, overrun=1; ready=1 for one cycle -> valid=0, overrun stays 1.
REQ-036 rst for one cycle while key 8 is held and valid=1 -> all outputs 0 after that edge; the held key produces code=4'b1000 again, with valid high 2+DEBOUNCE_CYCLES edges after rst is released.
